// File: rtl/cs3220_pkg.sv
// rtl/cs3220_pkg.sv - shared types and constants for the cs3220 writeback path
package cs3220_pkg;

  localparam int XLEN_DEF = 32;
  localparam int AW_DEF   = 4;

  localparam logic [AW_DEF-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [AW_DEF-1:0]   addr;
    logic [XLEN_DEF-1:0] data;
  } wbuf_entry_t;

endpackage

// File: rtl/wbuf_bypass_mux.sv
// rtl/wbuf_bypass_mux.sv - per-read-port forwarding: youngest channel, then newest buffer entry, then RF
module wbuf_bypass_mux
  import cs3220_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int AW     = 4,
  parameter int NUM_WB = 2,
  parameter int DEPTH  = 4
) (
  input  logic [AW-1:0]          rd_addr,
  input  logic [XLEN-1:0]        rf_rdata,
  input  logic [NUM_WB-1:0]      wb_valid,
  input  logic [NUM_WB*AW-1:0]   wb_addr,
  input  logic [NUM_WB*XLEN-1:0] wb_data,
  input  logic [DEPTH-1:0]       ent_valid,
  input  logic [DEPTH*AW-1:0]    ent_addr,
  input  logic [DEPTH*XLEN-1:0]  ent_data,
  output logic [XLEN-1:0]        rd_data
);

  // Later assignments win: entries are ordered oldest-first, channels scanned oldest-first.
  always_comb begin
    rd_data = rf_rdata;
    for (int k = 0; k < DEPTH; k++) begin
      if (ent_valid[k] && ent_addr[k*AW +: AW] == rd_addr) rd_data = ent_data[k*XLEN +: XLEN];
    end
    for (int i = NUM_WB - 1; i >= 0; i--) begin
      if (wb_valid[i] && wb_addr[i*AW +: AW] == rd_addr) rd_data = wb_data[i*XLEN +: XLEN];
    end
    if (rd_addr == AW'(REG_ZERO)) rd_data = '0;
  end

endmodule

// File: rtl/rf_write_buffer.sv
// rtl/rf_write_buffer.sv - multi-channel writeback buffer draining to one RF write port, with bypass
// Optional in-place merging of repeated destinations: WBUF_COALESCE_EN.
module rf_write_buffer
  import cs3220_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int AW     = 4,
  parameter int NUM_WB = 2,
  parameter int NUM_RD = 2,
  parameter int DEPTH  = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic [NUM_WB-1:0]      wb_valid,
  input  logic [NUM_WB*AW-1:0]   wb_addr,
  input  logic [NUM_WB*XLEN-1:0] wb_data,
  output logic                   o_wb_stall,
  output logic                   rf_we,
  output logic [AW-1:0]          rf_waddr,
  output logic [XLEN-1:0]        rf_wdata,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  input  logic [NUM_RD*XLEN-1:0] rf_rdata,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic                   o_overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  if (DEPTH < NUM_WB) begin : g_bad_depth
    $error("rf_write_buffer: DEPTH must be >= NUM_WB");
  end

  function automatic logic [PW-1:0] wrap(input int a);
    return PW'(a % DEPTH);
  endfunction

  logic [AW-1:0]   buf_addr [DEPTH];
  logic [XLEN-1:0] buf_data [DEPTH];
  logic [PW-1:0]   head;
  logic [CW-1:0]   count;
  logic            pop;

  logic [AW-1:0]   ch_addr [NUM_WB];
  logic [XLEN-1:0] ch_data [NUM_WB];
  logic [PW-1:0]   co_idx  [NUM_WB];
  logic [PW-1:0]   slot    [NUM_WB];
  logic [NUM_WB-1:0] cand, co_hit, keep;
  logic            drop;
  int              n_push, n_off;

  assign pop        = (count != '0);
  assign rf_we      = pop;
  assign rf_waddr   = pop ? buf_addr[head] : '0;
  assign rf_wdata   = pop ? buf_data[head] : '0;
  assign o_wb_stall = (int'(count) > DEPTH - NUM_WB);

  always_comb begin
    cand   = '0;
    co_hit = '0;
    keep   = '0;
    drop   = 1'b0;
    n_push = 0;
    n_off  = 0;
    for (int i = 0; i < NUM_WB; i++) begin
      ch_addr[i] = wb_addr[i*AW +: AW];
      ch_data[i] = wb_data[i*XLEN +: XLEN];
      co_idx[i]  = '0;
      slot[i]    = '0;
    end
    for (int i = 0; i < NUM_WB; i++) begin
      cand[i] = wb_valid[i] && (ch_addr[i] != AW'(REG_ZERO));
      for (int j = 0; j < i; j++) begin
        if (wb_valid[j] && ch_addr[j] == ch_addr[i]) cand[i] = 1'b0;
      end
    end
`ifdef WBUF_COALESCE_EN
    // The head is being written out this cycle, so only entries behind it may absorb a push.
    for (int i = 0; i < NUM_WB; i++) begin
      for (int k = 1; k < DEPTH; k++) begin
        if (cand[i] && k < int'(count) && buf_addr[wrap(int'(head) + k)] == ch_addr[i]) begin
          co_hit[i] = 1'b1;
          co_idx[i] = wrap(int'(head) + k);
        end
      end
    end
`endif
    // Free slots are granted youngest channel first, so overflow drops the oldest.
    for (int i = 0; i < NUM_WB; i++) begin
      if (cand[i] && !co_hit[i]) begin
        if (n_push < DEPTH - int'(count)) begin
          keep[i] = 1'b1;
          n_push  = n_push + 1;
        end else begin
          drop = 1'b1;
        end
      end
    end
    for (int i = NUM_WB - 1; i >= 0; i--) begin
      if (keep[i]) begin
        slot[i] = wrap(int'(head) + int'(count) + n_off);
        n_off   = n_off + 1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      head       <= '0;
      count      <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (pop) head <= wrap(int'(head) + 1);
      count      <= CW'(int'(count) + n_push - (pop ? 1 : 0));
      o_overflow <= o_overflow | drop;
    end
  end

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NUM_WB; i++) begin
      if (keep[i]) begin
        buf_addr[slot[i]] <= ch_addr[i];
        buf_data[slot[i]] <= ch_data[i];
      end
      if (co_hit[i]) buf_data[co_idx[i]] <= ch_data[i];
    end
  end

  logic [DEPTH-1:0]      ent_valid;
  logic [DEPTH*AW-1:0]   ent_addr;
  logic [DEPTH*XLEN-1:0] ent_data;

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      ent_valid[k]              = (k < int'(count));
      ent_addr[k*AW +: AW]      = buf_addr[wrap(int'(head) + k)];
      ent_data[k*XLEN +: XLEN]  = buf_data[wrap(int'(head) + k)];
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    wbuf_bypass_mux #(
      .XLEN(XLEN), .AW(AW), .NUM_WB(NUM_WB), .DEPTH(DEPTH)
    ) u_mux (
      .rd_addr  (rd_addr[p*AW +: AW]),
      .rf_rdata (rf_rdata[p*XLEN +: XLEN]),
      .wb_valid (wb_valid),
      .wb_addr  (wb_addr),
      .wb_data  (wb_data),
      .ent_valid(ent_valid),
      .ent_addr (ent_addr),
      .ent_data (ent_data),
      .rd_data  (rd_data[p*XLEN +: XLEN])
    );
  end

endmodule

// File: tb/tb_rf_write_buffer.sv
// tb/tb_rf_write_buffer.sv - directed self-checking bench for rf_write_buffer (both WBUF_COALESCE_EN builds)
module tb_rf_write_buffer;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic [1:0]  wb_valid;
  logic [7:0]  wb_addr;
  logic [63:0] wb_data;
  logic        o_wb_stall, rf_we, o_overflow;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [7:0]  rd_addr;
  logic [63:0] rf_rdata, rd_data;

  int errors = 0;
  int checks = 0;

  rf_write_buffer dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .o_wb_stall(o_wb_stall), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rd_addr(rd_addr), .rf_rdata(rf_rdata), .rd_data(rd_data), .o_overflow(o_overflow)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [3:0] a0, input logic [31:0] d0,
                       input logic [3:0] a1, input logic [31:0] d1);
    wb_valid = v;
    wb_addr  = {a1, a0};
    wb_data  = {d1, d0};
    #1;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wr(input string tag, input logic we, input logic [3:0] a, input logic [31:0] d);
    check({tag, "_we"}, {31'd0, rf_we}, {31'd0, we});
    if (we) begin
      check({tag, "_waddr"}, {28'd0, rf_waddr}, {28'd0, a});
      check({tag, "_wdata"}, rf_wdata, d);
    end
  endtask

  task automatic do_reset();
    i_reset_n = 1'b0;
    #1;
    i_reset_n = 1'b1;
    tick();
  endtask

  initial begin
    i_reset_n = 1'b0;
    wb_valid = '0; wb_addr = '0; wb_data = '0; rd_addr = '0; rf_rdata = '0;
    #1;
    wr("rst", 1'b0, 4'd0, 32'd0);
    check("rst_waddr", {28'd0, rf_waddr}, 32'd0);
    check("rst_wdata", rf_wdata, 32'd0);
    check("rst_stall", {31'd0, o_wb_stall}, 32'd0);
    check("rst_ovf", {31'd0, o_overflow}, 32'd0);
    repeat (2) @(posedge i_clk);
    #1 i_reset_n = 1'b1;

    // single write, bypass in push and drain cycles
    rd_addr = {4'd0, 4'd3}; rf_rdata = {32'h0, 32'hDEAD};
    drive(2'b01, 4'd3, 32'h11, 4'd0, 32'h0);
    check("t1_byp_push", rd_data[31:0], 32'h11);
    wr("t1_push", 1'b0, 4'd0, 32'd0);
    tick(); drive(2'b00, 4'd0, 0, 4'd0, 0);
    wr("t1_drain", 1'b1, 4'd3, 32'h11);
    check("t1_byp_drain", rd_data[31:0], 32'h11);
    tick(); rf_rdata = {32'h0, 32'h5555}; #1;
    wr("t1_empty", 1'b0, 4'd0, 32'd0);
    check("t1_rf_fallback", rd_data[31:0], 32'h5555);

    // two channels, older channel drains first
    rd_addr = {4'd6, 4'd5}; rf_rdata = '0;
    drive(2'b11, 4'd5, 32'hAA, 4'd6, 32'hBB);
    check("t2_byp5_push", rd_data[31:0], 32'hAA);
    check("t2_byp6_push", rd_data[63:32], 32'hBB);
    tick(); drive(2'b00, 4'd0, 0, 4'd0, 0);
    wr("t2_first", 1'b1, 4'd6, 32'hBB);
    check("t2_byp5_d1", rd_data[31:0], 32'hAA);
    check("t2_byp6_d1", rd_data[63:32], 32'hBB);
    tick(); rf_rdata = {32'h66, 32'h0}; #1;
    wr("t2_second", 1'b1, 4'd5, 32'hAA);
    check("t2_byp5_d2", rd_data[31:0], 32'hAA);
    check("t2_byp6_d2", rd_data[63:32], 32'h66);
    tick();
    wr("t2_empty", 1'b0, 4'd0, 32'd0);

    // same-cycle duplicate: youngest kept
    rd_addr = {4'd0, 4'd7}; rf_rdata = '0;
    drive(2'b11, 4'd7, 32'h1, 4'd7, 32'h2);
    check("t3_byp_push", rd_data[31:0], 32'h1);
    tick(); drive(2'b00, 4'd0, 0, 4'd0, 0);
    wr("t3_drain", 1'b1, 4'd7, 32'h1);
    check("t3_byp_drain", rd_data[31:0], 32'h1);
    tick();
    wr("t3_single", 1'b0, 4'd0, 32'd0);

    // fill, stall, overflow drops oldest channel (r9)
    rd_addr = '0;
    drive(2'b11, 4'd1, 32'h101, 4'd2, 32'h102);
    check("t4_stall0", {31'd0, o_wb_stall}, 32'd0);
    tick(); drive(2'b11, 4'd3, 32'h103, 4'd4, 32'h104);
    check("t4_stall_c2", {31'd0, o_wb_stall}, 32'd0);
    wr("t4_w0", 1'b1, 4'd2, 32'h102);
    tick(); drive(2'b11, 4'd8, 32'h108, 4'd9, 32'h109);
    check("t4_stall_c3", {31'd0, o_wb_stall}, 32'd1);
    check("t4_ovf_before", {31'd0, o_overflow}, 32'd0);
    wr("t4_w1", 1'b1, 4'd1, 32'h101);
    tick(); drive(2'b00, 4'd0, 0, 4'd0, 0);
    check("t4_ovf_set", {31'd0, o_overflow}, 32'd1);
    check("t4_stall_hold", {31'd0, o_wb_stall}, 32'd1);
    wr("t4_w2", 1'b1, 4'd4, 32'h104);
    tick(); wr("t4_w3", 1'b1, 4'd3, 32'h103);
    tick(); wr("t4_w4", 1'b1, 4'd8, 32'h108);
    tick(); wr("t4_empty", 1'b0, 4'd0, 32'd0);
    do_reset();
    check("t4_ovf_cleared", {31'd0, o_overflow}, 32'd0);

    // repeated destination behind the head
    rd_addr = {4'd0, 4'd4}; rf_rdata = '0;
    drive(2'b11, 4'd4, 32'h10, 4'd1, 32'h77);
    tick(); drive(2'b01, 4'd4, 32'h20, 4'd0, 0);
    wr("t5_w0", 1'b1, 4'd1, 32'h77);
    check("t5_byp_push", rd_data[31:0], 32'h20);
    tick(); drive(2'b00, 4'd0, 0, 4'd0, 0);
    check("t5_byp_buf", rd_data[31:0], 32'h20);
`ifdef WBUF_COALESCE_EN
    wr("t5_w1", 1'b1, 4'd4, 32'h20);
    tick(); wr("t5_empty", 1'b0, 4'd0, 32'd0);
`else
    wr("t5_w1", 1'b1, 4'd4, 32'h10);
    tick(); wr("t5_w2", 1'b1, 4'd4, 32'h20);
    tick(); wr("t5_empty", 1'b0, 4'd0, 32'd0);
`endif

    // async reset with three entries pending
    drive(2'b11, 4'd10, 32'hA0, 4'd11, 32'hB0);
    tick(); drive(2'b11, 4'd12, 32'hC0, 4'd13, 32'hD0);
    tick(); drive(2'b00, 4'd0, 0, 4'd0, 0);
    check("t6_stall_pending", {31'd0, o_wb_stall}, 32'd1);
    #2 i_reset_n = 1'b0;
    #1;
    wr("t6_in_reset", 1'b0, 4'd0, 32'd0);
    check("t6_stall_reset", {31'd0, o_wb_stall}, 32'd0);
    i_reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      wr("t6_after", 1'b0, 4'd0, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
